// File: rtl/enc_8to3_seq.sv
// Sequential 8-to-3 encoder: accepts an 8-bit request word and emits the
// index of every set bit, lowest first, one index per output handshake.
module enc_8to3_seq (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       IN_VALID,
    output logic       IN_READY,
    input  logic [7:0] IN,
    output logic       OUT_VALID,
    input  logic       OUT_READY,
    output logic [2:0] OUT,
    output logic       OUT_LAST,
    output logic [3:0] COUNT,
    output logic       ZERO
);

    localparam int unsigned WORD_W = 8;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned CNT_W  = 4;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [WORD_W-1:0] pend_q,  pend_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              zero_q,  zero_d;

    logic [IDX_W-1:0]  low_idx;
    logic              one_left;
    logic [CNT_W-1:0]  in_pop;

    // Lowest set bit of the pending word; scanning downward leaves the lowest.
    always_comb begin
        low_idx = '0;
        for (int i = WORD_W - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    // Exactly one bit left means the current beat is the last of the word.
    assign one_left = (pend_q != '0) && ((pend_q & (pend_q - WORD_W'(1))) == '0);

    always_comb begin
        in_pop = '0;
        for (int i = 0; i < WORD_W; i++) begin
            in_pop = in_pop + CNT_W'(IN[i]);
        end
    end

    // Next-state logic: capture in IDLE, drain one bit per accepted beat in EMIT.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        count_d = count_q;
        zero_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (IN_VALID) begin
                    count_d = in_pop;
                    if (IN == '0) begin
                        zero_d = 1'b1;
                    end else begin
                        pend_d  = IN;
                        state_d = ST_EMIT;
                    end
                end
            end
            ST_EMIT: begin
                if (OUT_READY) begin
                    pend_d = pend_q & (pend_q - WORD_W'(1));
                    if (one_left) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                pend_d  = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            count_q <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            count_q <= count_d;
            zero_q  <= zero_d;
        end
    end

    // All outputs are decoded from registers only.
    assign IN_READY  = (state_q == ST_IDLE);
    assign OUT_VALID = (state_q == ST_EMIT);
    assign OUT       = OUT_VALID ? low_idx : '0;
    assign OUT_LAST  = OUT_VALID & one_left;
    assign COUNT     = count_q;
    assign ZERO      = zero_q;

endmodule

// File: tb/tb_enc_8to3_seq.sv
// Self-checking bench for enc_8to3_seq: directed scenarios plus randomized
// words with random backpressure checked against a bit-list reference model.
module tb_enc_8to3_seq;

    logic       CLK;
    logic       RST_N;
    logic       IN_VALID;
    logic       IN_READY;
    logic [7:0] IN;
    logic       OUT_VALID;
    logic       OUT_READY;
    logic [2:0] OUT;
    logic       OUT_LAST;
    logic [3:0] COUNT;
    logic       ZERO;

    int total = 0;
    int bad   = 0;

    enc_8to3_seq dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN        (IN),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT       (OUT),
        .OUT_LAST  (OUT_LAST),
        .COUNT     (COUNT),
        .ZERO      (ZERO)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Reference: list of set-bit positions in ascending order.
    function automatic void model_bits(input logic [7:0] w, output int q[$]);
        q = {};
        for (int i = 0; i < 8; i++) begin
            if (((w >> i) & 8'd1) == 8'd1) q.push_back(i);
        end
    endfunction

    task automatic test_reset();
        RST_N = 1'b0; IN_VALID = 1'b0; IN = 8'h00; OUT_READY = 1'b0;
        step(); step();
        #2 RST_N = 1'b1;
        step();
        total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", OUT_VALID); end
        total++; if (OUT !== 3'd0) begin bad++; $display("FAIL reset_out got=%0d exp=0", OUT); end
        total++; if (OUT_LAST !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%0b exp=0", OUT_LAST); end
        total++; if (COUNT !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", COUNT); end
        total++; if (ZERO !== 1'b0) begin bad++; $display("FAIL reset_zero got=%0b exp=0", ZERO); end
        total++; if (IN_READY !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", IN_READY); end
    endtask

    task automatic test_onehot();
        logic [7:0] w;
        logic [7:0] dec;
        for (int k = 0; k < 8; k++) begin
            w = 8'd1 << k;
            IN = w; IN_VALID = 1'b1; OUT_READY = 1'b1;
            total++; if (IN_READY !== 1'b1) begin bad++; $display("FAIL onehot_ready k=%0d got=%0b exp=1", k, IN_READY); end
            step();
            IN_VALID = 1'b0; IN = 8'h00;
            dec = 8'd1 << OUT;
            total++; if (OUT_VALID !== 1'b1 || OUT !== 3'(k) || OUT_LAST !== 1'b1)
                begin bad++; $display("FAIL onehot_beat k=%0d got v=%0b out=%0d last=%0b exp v=1 out=%0d last=1", k, OUT_VALID, OUT, OUT_LAST, k); end
            total++; if (COUNT !== 4'd1) begin bad++; $display("FAIL onehot_count k=%0d got=%0d exp=1", k, COUNT); end
            total++; if (dec !== w) begin bad++; $display("FAIL onehot_roundtrip k=%0d got=%h exp=%h", k, dec, w); end
            step();
            total++; if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1)
                begin bad++; $display("FAIL onehot_idle k=%0d got v=%0b rdy=%0b exp v=0 rdy=1", k, OUT_VALID, IN_READY); end
        end
    endtask

    task automatic test_multihot();
        int q[$];
        model_bits(8'b10100110, q);
        IN = 8'b10100110; IN_VALID = 1'b1; OUT_READY = 1'b1;
        step();
        IN_VALID = 1'b0; IN = 8'h00;
        foreach (q[j]) begin
            total++; if (OUT_VALID !== 1'b1 || OUT !== 3'(q[j]) || OUT_LAST !== (j == q.size() - 1))
                begin bad++; $display("FAIL multihot_beat j=%0d got v=%0b out=%0d last=%0b exp out=%0d", j, OUT_VALID, OUT, OUT_LAST, q[j]); end
            total++; if (IN_READY !== 1'b0 || COUNT !== 4'd4)
                begin bad++; $display("FAIL multihot_status j=%0d got rdy=%0b cnt=%0d exp rdy=0 cnt=4", j, IN_READY, COUNT); end
            step();
        end
        total++; if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0)
            begin bad++; $display("FAIL multihot_end got rdy=%0b v=%0b exp rdy=1 v=0", IN_READY, OUT_VALID); end
    endtask

    task automatic test_backpressure();
        int q[$];
        int j;
        int cyc;
        model_bits(8'hFF, q);
        IN = 8'hFF; IN_VALID = 1'b1; OUT_READY = 1'b1;
        step();
        IN_VALID = 1'b0; IN = 8'h00;
        j = 0; cyc = 0;
        while (OUT_VALID === 1'b1 && cyc < 64) begin
            OUT_READY = (cyc % 2) == 1;
            total++; if (j >= q.size() || OUT !== 3'(q[j]) || OUT_LAST !== (j == q.size() - 1))
                begin bad++; $display("FAIL bp_beat cyc=%0d got out=%0d last=%0b exp beat=%0d", cyc, OUT, OUT_LAST, j); end
            if (OUT_READY) j++;
            step();
            cyc++;
        end
        OUT_READY = 1'b1;
        total++; if (cyc !== 16) begin bad++; $display("FAIL bp_cycles got=%0d exp=16", cyc); end
        total++; if (j !== 8) begin bad++; $display("FAIL bp_beats got=%0d exp=8", j); end
        total++; if (COUNT !== 4'd8) begin bad++; $display("FAIL bp_count got=%0d exp=8", COUNT); end
    endtask

    task automatic test_zero_collision();
        IN = 8'h00; IN_VALID = 1'b1; OUT_READY = 1'b1;
        step();
        IN_VALID = 1'b0;
        total++; if (ZERO !== 1'b1 || COUNT !== 4'd0 || OUT_VALID !== 1'b0 || IN_READY !== 1'b1)
            begin bad++; $display("FAIL zero_pulse got z=%0b cnt=%0d v=%0b rdy=%0b exp z=1 cnt=0 v=0 rdy=1", ZERO, COUNT, OUT_VALID, IN_READY); end
        step();
        total++; if (ZERO !== 1'b0) begin bad++; $display("FAIL zero_clear got=%0b exp=0", ZERO); end
        IN = 8'h03; IN_VALID = 1'b1;
        step();
        IN = 8'h80;
        total++; if (OUT !== 3'd0 || OUT_LAST !== 1'b0 || COUNT !== 4'd2)
            begin bad++; $display("FAIL coll_beat0 got out=%0d last=%0b cnt=%0d exp 0 0 2", OUT, OUT_LAST, COUNT); end
        step();
        total++; if (OUT !== 3'd1 || OUT_LAST !== 1'b1 || COUNT !== 4'd2)
            begin bad++; $display("FAIL coll_beat1 got out=%0d last=%0b cnt=%0d exp 1 1 2", OUT, OUT_LAST, COUNT); end
        step();
        total++; if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0 || COUNT !== 4'd2)
            begin bad++; $display("FAIL coll_idle got rdy=%0b v=%0b cnt=%0d exp 1 0 2", IN_READY, OUT_VALID, COUNT); end
        step();
        IN_VALID = 1'b0; IN = 8'h00;
        total++; if (OUT_VALID !== 1'b1 || OUT !== 3'd7 || COUNT !== 4'd1)
            begin bad++; $display("FAIL coll_second got v=%0b out=%0d cnt=%0d exp 1 7 1", OUT_VALID, OUT, COUNT); end
        step();
    endtask

    task automatic test_reset_mid();
        IN = 8'h0F; IN_VALID = 1'b1; OUT_READY = 1'b1;
        step();
        IN_VALID = 1'b0;
        step();
        total++; if (OUT !== 3'd1 || OUT_VALID !== 1'b1)
            begin bad++; $display("FAIL rmid_beat2 got v=%0b out=%0d exp 1 1", OUT_VALID, OUT); end
        #2 RST_N = 1'b0;
        #1;
        total++; if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1)
            begin bad++; $display("FAIL rmid_async got v=%0b rdy=%0b exp 0 1", OUT_VALID, IN_READY); end
        IN = 8'h55; IN_VALID = 1'b1;
        step();
        total++; if (COUNT !== 4'd0 || OUT_VALID !== 1'b0)
            begin bad++; $display("FAIL rmid_no_capture got cnt=%0d v=%0b exp 0 0", COUNT, OUT_VALID); end
        IN_VALID = 1'b0; IN = 8'h00;
        #2 RST_N = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            total++; if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1)
                begin bad++; $display("FAIL rmid_residual c=%0d got v=%0b rdy=%0b exp 0 1", c, OUT_VALID, IN_READY); end
        end
    endtask

    task automatic test_random();
        int q[$];
        logic [7:0] w;
        int j;
        int cyc;
        for (int n = 0; n < 150; n++) begin
            w = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            model_bits(w, q);
            IN = w; IN_VALID = 1'b1;
            total++; if (IN_READY !== 1'b1) begin bad++; $display("FAIL rnd_ready n=%0d got=%0b exp=1", n, IN_READY); end
            step();
            total++; if (COUNT !== 4'(q.size()) || ZERO !== (w == 8'h00))
                begin bad++; $display("FAIL rnd_status n=%0d w=%h got cnt=%0d z=%0b exp cnt=%0d", n, w, COUNT, ZERO, q.size()); end
            j = 0; cyc = 0;
            while (j < q.size() && cyc < 200) begin
                IN_VALID = $urandom_range(0, 1) == 1;
                IN = 8'($urandom);
                OUT_READY = $urandom_range(0, 2) != 0;
                total++; if (OUT_VALID !== 1'b1 || OUT !== 3'(q[j]) || OUT_LAST !== (j == q.size() - 1) || IN_READY !== 1'b0)
                    begin bad++; $display("FAIL rnd_beat n=%0d j=%0d got v=%0b out=%0d last=%0b exp out=%0d", n, j, OUT_VALID, OUT, OUT_LAST, q[j]); end
                if (OUT_READY) j++;
                step();
                cyc++;
            end
            total++; if (cyc >= 200) begin bad++; $display("FAIL rnd_timeout n=%0d beats=%0d", n, j); end
            IN_VALID = 1'b0;
            total++; if (OUT_VALID !== 1'b0 || COUNT !== 4'(q.size()))
                begin bad++; $display("FAIL rnd_end n=%0d got v=%0b cnt=%0d exp v=0 cnt=%0d", n, OUT_VALID, COUNT, q.size()); end
        end
    endtask

    initial begin
        test_reset();
        test_onehot();
        test_multihot();
        test_backpressure();
        test_zero_collision();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
